// File: rtl/phase_countdown_timer.sv
// Per-phase countdown timer: 1 s prescaler, remaining-seconds counter and expire pulse.
// Optional one-shot phase extension is enabled by defining PHASE_TIMER_EXTEND_EN.
module phase_countdown_timer #(
   parameter int CLK_DIV = 100_000_000,
   parameter int DUR0    = 9,
   parameter int DUR1    = 4,
   parameter int DUR2    = 9,
   parameter int DUR3    = 4,
   parameter int EXT_SEC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] phase_sel,
`ifdef PHASE_TIMER_EXTEND_EN
   input  logic       extend,
`endif
   output logic       tick_1s,
   output logic [3:0] count,
   output logic       expire
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   // A zero duration would skip the phase entirely, so it is promoted to 1.
   function automatic logic [3:0] fix_dur(input int d);
      return (d == 0) ? 4'd1 : 4'(d);
   endfunction

   localparam logic [3:0] DUR0_FIX = fix_dur(DUR0);
   localparam logic [3:0] DUR1_FIX = fix_dur(DUR1);
   localparam logic [3:0] DUR2_FIX = fix_dur(DUR2);
   localparam logic [3:0] DUR3_FIX = fix_dur(DUR3);

   logic [PW-1:0] presc;
   logic          tick_edge;
   logic          reload;
   logic          ext_fire;
   logic [3:0]    reload_val;
   logic [4:0]    ext_sum;
   logic [3:0]    ext_val;

   assign tick_edge = run && (presc == PRESC_MAX);
   assign reload    = tick_edge && (count == 4'd0);

   // Reload selects the duration of the phase that follows the one now shown.
   always_comb begin
      // NOTE: every combinational output gets a default so no latch is inferred.
      reload_val = DUR0_FIX;
      case (phase_sel)
         2'd0:    reload_val = DUR1_FIX;
         2'd1:    reload_val = DUR2_FIX;
         2'd2:    reload_val = DUR3_FIX;
         default: reload_val = DUR0_FIX;
      endcase
   end

   // Saturate at 15 first, then take off the second elapsing on this same edge.
   assign ext_sum = {1'b0, count} + 5'(EXT_SEC);
   assign ext_val = ((ext_sum > 5'd15) ? 4'd15 : ext_sum[3:0]) - {3'b000, tick_edge};

`ifdef PHASE_TIMER_EXTEND_EN
   logic ext_used;

   assign ext_fire = extend && run && !ext_used && (count != 4'd0);

   always_ff @(posedge clk) begin
      if (rst)
         ext_used <= 1'b0;
      else if (reload)
         ext_used <= 1'b0;
      else if (ext_fire)
         ext_used <= 1'b1;
   end
`else
   assign ext_fire = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         count   <= DUR0_FIX;
         tick_1s <= 1'b0;
         expire  <= 1'b0;
      end else begin
         tick_1s <= tick_edge;
         expire  <= reload;
         if (run)
            presc <= tick_edge ? '0 : presc + PW'(1);
         if (reload)
            count <= reload_val;
         else if (ext_fire)
            count <= ext_val;
         else if (tick_edge)
            count <= count - 4'd1;
      end
   end

endmodule
